// File: rtl/serial_ha_adder.sv
// -----------------------------------------------------------------------------
// serial_ha_adder
//
// Bit-serial adder built from one full-adder slice (two cascaded half-adder
// cells plus an OR gate) and a single carry flop. One operand bit pair is
// consumed per clock, LSB first. A start/busy/done handshake lets multi-bit
// operands share that one slice.
//
// Timing (edge E0 = the edge that accepts start):
//   E0            operands latched, state -> RUN, busy rises
//   E1 .. EW      one bit per edge; at EW sum/cout update, state -> DONE
//   cycle after EW done = 1 for one cycle
//   EW+1          state -> IDLE, busy falls
//   EW+2          earliest edge a new start can be accepted
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous reset, active-high, priority over start
//   start  in   1      request, accepted only while busy = 0
//   a      in   WIDTH  operand A, sampled on the accepting edge only
//   b      in   WIDTH  operand B, sampled on the accepting edge only
//   cin    in   1      carry-in, sampled on the accepting edge only
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  last completed sum (held)
//   cout   out  1      last completed carry-out (held)
//
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------

// Single half-adder cell; two of these plus an OR form the full-adder slice.
module half_adder_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_ha_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CNT_W-1:0] bitcnt;

    // Full-adder slice signals
    logic             s0;
    logic             c0;
    logic             bit_s;
    logic             c1;
    logic             carry_nxt;
    logic [WIDTH-1:0] psum_nxt;
    logic             last_bit;

    // -------------------------------------------------------------------------
    // Full-adder slice: HA1 adds the operand bits, HA2 folds in the carry.
    // -------------------------------------------------------------------------
    half_adder_cell u_ha1 (
        .x (sh_a[0]),
        .y (sh_b[0]),
        .s (s0),
        .c (c0)
    );

    half_adder_cell u_ha2 (
        .x (s0),
        .y (carry),
        .s (bit_s),
        .c (c1)
    );

    assign carry_nxt = c0 | c1;

    // New bit enters at the MSB; after WIDTH right shifts bit 0 lands at LSB.
    assign psum_nxt  = {bit_s, psum[WIDTH-1:1]};
    assign last_bit  = (bitcnt == LAST_BIT);

    // -------------------------------------------------------------------------
    // FSM next-state and registered-output next values
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold it.
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase

        // busy/done are flopped from the next state so they are clean
        // register outputs with no path back to start.
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    // -------------------------------------------------------------------------
    // FSM state register plus handshake outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: operand shifters, carry flop, bit counter, result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            bitcnt <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        carry  <= cin;
                        bitcnt <= '0;
                        psum   <= '0;
                    end
                end
                RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    carry  <= carry_nxt;
                    psum   <= psum_nxt;
                    // bitcnt stops at LAST_BIT; state leaves RUN on that edge
                    // and the next accept reloads it.
                    if (!last_bit) begin
                        bitcnt <= bitcnt + 1'b1;
                    end else begin
                        sum  <= psum_nxt;
                        cout <= carry_nxt;
                    end
                end
                DONE: begin
                    // Results are held; start is ignored here.
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ha_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_ha_adder
//
// Self-checking bench for serial_ha_adder (WIDTH = 8). A timing/arithmetic
// reference model predicts busy, done, sum and cout every cycle; directed
// scenarios add literal expectations, then 200 randomized operations follow.
// -----------------------------------------------------------------------------
module tb_serial_ha_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_pass   = 0;

    serial_ha_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // -------------------------------------------------------------------------
    // Reference model. An accepted operation occupies WIDTH+2 cycles:
    // m_left counts cycles until the adder is free again. The result
    // appears (and done pulses) when one cycle remains.
    // -------------------------------------------------------------------------
    int               cyc      = 0;
    int               m_left   = 0;
    logic [WIDTH:0]   m_result = '0;
    logic [WIDTH-1:0] m_sum    = '0;
    logic             m_cout   = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_left = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_left == 0) begin
            if (start === 1'b1) begin
                m_result = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
                m_left   = WIDTH + 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) {m_cout, m_sum} = m_result;
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle compare against the model, plus done-pulse timestamps.
    // -------------------------------------------------------------------------
    bit checking  = 1'b0;
    int last_done = 0;
    int prev_done = 0;

    always @(posedge clk) begin
        #1;
        if (checking) begin
            check("cyc_busy", busy, (m_left != 0));
            check("cyc_done", done, (m_left == 1));
            check("cyc_sum",  sum,  m_sum);
            check("cyc_cout", cout, m_cout);
        end
        if (done === 1'b1) begin
            prev_done = last_done;
            last_done = cyc;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    // Wait for idle, present operands with a one-cycle start; returns at the
    // falling edge just after the accepting edge.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_start", busy, 1'b0);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for a done pulse; returns at posedge+1 of the done cycle.
    // With scramble set, inputs and start are randomized while waiting.
    task automatic wait_done(input bit scramble);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            if (scramble) begin
                @(negedge clk);
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                cin   = 1'($urandom);
                start = 1'($urandom);
            end
            @(posedge clk);
            #1;
            seen = (done === 1'b1);
            n++;
        end
        check("done_seen", seen, 1'b1);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int c0;
        bit saw;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sum",  sum,  8'h00);
        check("reset_cout", cout, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        checking = 1'b1;

        // 0F + 01: busy next cycle, done 8 cycles after acceptance
        do_op(8'h0F, 8'h01, 1'b0);
        c0 = cyc;
        check("t1_busy_after_accept", busy, 1'b1);
        wait_done(1'b0);
        check("t1_latency", last_done - c0, WIDTH);
        check("t1_sum",  sum,  8'h10);
        check("t1_cout", cout, 1'b0);

        // Full carry ripple, then all-ones with carry-in
        do_op(8'hFF, 8'h01, 1'b0);
        wait_done(1'b0);
        check("t2_sum",  sum,  8'h00);
        check("t2_cout", cout, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1);
        wait_done(1'b0);
        check("t3_sum",  sum,  8'hFF);
        check("t3_cout", cout, 1'b1);

        // Start held high, a changed mid-operation
        @(negedge clk);
        while (busy !== 1'b0) @(negedge clk);
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a     = 8'hAA;
        wait_done(1'b0);
        check("t4_sum",  sum,  8'h46);
        check("t4_cout", cout, 1'b0);
        @(posedge clk);
        #1;
        check("t4_idle_gap", busy, 1'b0);
        @(posedge clk);
        #1;
        check("t4_reaccept", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);
        check("t4b_sum", sum, 8'hDE);

        // Reset at the 4th RUN edge abandons the operation
        do_op(8'hA5, 8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_sum",  sum,  8'h00);
        check("t5_cout", cout, 1'b0);
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw = 1'b1;
        end
        check("t5_no_done", saw, 1'b0);
        do_op(8'h01, 8'h01, 1'b0);
        wait_done(1'b0);
        check("t5_fresh_sum", sum, 8'h02);

        // Back-to-back spacing
        do_op(8'h33, 8'h44, 1'b1);
        wait_done(1'b0);
        do_op(8'h80, 8'h80, 1'b0);
        wait_done(1'b0);
        check("t6_spacing", last_done - prev_done, WIDTH + 2);
        check("t6_sum",  sum,  8'h00);
        check("t6_cout", cout, 1'b1);

        // Randomized operations with inputs scrambled while busy
        for (int i = 0; i < 200; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc);
            wait_done(1'b1);
            check("rand_result", {cout, sum}, (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rc));
            @(negedge clk);
            start = 1'b0;
        end

        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_ha_adder.md
Name: serial_ha_adder

Overview:
- Bit-serial multi-bit adder that consumes operands from the dedicated input pins and presents results on the dedicated output pins of the half-adder top-level.
- Each bit is formed from two cascaded half-adder cells plus an OR gate, giving a full-adder slice.
- Adds one bit per clock, LSB first, using a single carry flop.
- Replaces the purely combinational path with a start/busy/done handshake so multi-bit operands share one adder slice.

Parameters:
WIDTH, 8, operand and sum width in bits (minimum 2)

Ports:
clk    input   1      clock; all state updates on rising edge
rst    input   1      synchronous reset, active-high
start  input   1      request; accepted on a rising edge when busy=0
a      input   WIDTH  operand A; sampled only on the accepting edge
b      input   WIDTH  operand B; sampled only on the accepting edge
cin    input   1      carry-in; sampled only on the accepting edge
busy   output  1      high while an operation is in progress (RUN or DONE state)
done   output  1      one-cycle pulse; result valid
sum    output  WIDTH  result; holds last completed value
cout   output  1      carry-out of the MSB; holds last completed value

Behaviour:
- Reset: rst=1 at a rising edge forces the following, regardless of state:
  - state=IDLE, busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry flop and bit counter cleared
  - An operation in flight is abandoned with no done pulse.
  - rst has priority over start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → RUN.
  - Load shA=a, shB=b, carry=cin, bitcnt=0, partial-sum register cleared.
  - start=0 → remain in IDLE.
- RUN: at each edge:
  - s0 = shA[0] XOR shB[0]; c0 = shA[0] AND shB[0] (half adder 1)
  - bit = s0 XOR carry; c1 = s0 AND carry (half adder 2)
  - carry ← c0 OR c1
  - Shift bit into the partial-sum MSB with a right-shift, so after WIDTH shifts bit 0 sits at the LSB.
  - shA, shB shift right by 1; bitcnt increments.
  - On the edge where bitcnt==WIDTH-1 (edge E_WIDTH), the final value goes to the outputs and the state moves to DONE:
    - sum ← completed partial sum
    - cout ← final carry
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge → IDLE, done=0.
- Latency:
  - start accepted at E0; done high during the cycle after edge E_WIDTH (WIDTH cycles after acceptance).
  - Next start can be accepted at edge E_WIDTH+2.
  - Throughput is one operation per WIDTH+2 cycles.
- busy:
  - Registered; 1 in RUN and DONE, 0 in IDLE.
  - Rises in the cycle after E0; falls in the cycle after DONE.
- start while busy=1 (RUN or DONE) is ignored entirely: no re-sampling of a/b/cin and no effect on the current operation.
- a, b and cin may change freely after E0 without affecting the result.
- sum and cout change only at E_WIDTH or on reset; they are stable from then until the next completion.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1); no truncation or saturation.
- bitcnt is sized $clog2(WIDTH) bits; it does not wrap mid-operation.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=8; a=8'h0F, b=8'h01, cin=0, one-cycle start → busy=1 next cycle; done pulses 8 cycles after acceptance; sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 → full carry ripple; sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Start a=8'h12, b=8'h34; hold start high and change a=8'hAA during RUN/DONE → single done pulse; sum=8'h46, cout=0; a second operation begins only at the first edge with busy=0.
- Start a=8'hA5, b=8'h5A; assert rst for 1 cycle at the 4th RUN edge → busy=0, done=0, sum=0, cout=0 next cycle; no done pulse follows. A fresh start with a=8'h01, b=8'h01 yields sum=8'h02.
- Back-to-back: start re-asserted on the first cycle busy=0 → operations complete at a spacing of 10 cycles.
- Randomised 200 operations: {cout,sum} matches a+b+cin every time, and done is exactly one cycle wide.
